mem_io_ctrl: RTL and testbench
==============================

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter WordSize, default 16, SHALL set the data word width.
REQ-002 Parameter MemAddrSize, default 15, SHALL set the CPU data address width.
REQ-003 Parameter RamAddrSize, default 8, SHALL set internal RAM depth to 2^RamAddrSize words.
REQ-004 Parameter FifoDepth, default 4 (power of two, at least 2), SHALL set the TX FIFO depth.
REQ-005 Port list SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- addressM  in  MemAddrSize  CPU data address.
- outM  in  WordSize  CPU write data.
- writeM  in  1  CPU write enable.
- inM  out  WordSize  read data to CPU.
- tx_data  out  WordSize  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head.
- rx_data  in  WordSize  input word.
- rx_strobe  in  1  one-cycle pulse: rx_data valid.

Function
REQ-006 The address map SHALL be:
- addressM[MemAddrSize-1]=0: RAM, indexed by addressM[RamAddrSize-1:0], aliased.
- 0x6000 OUT_DATA.
- 0x6001 STATUS.
- 0x6002 IN_DATA.
- Any other address with the MSB set SHALL read 0 and ignore writes.
REQ-007 inM SHALL be combinational from addressM in the same cycle, with no read side effects.
REQ-008 Writes SHALL take effect at the rising clk edge when writeM=1.
REQ-009 A RAM write SHALL store outM; a read SHALL return the stored word.
REQ-010 A write to OUT_DATA SHALL push outM into the TX FIFO.
REQ-011 A read of OUT_DATA SHALL return the zero-extended FIFO occupancy count.
REQ-012 A read of STATUS SHALL return:
- bit0 tx_full
- bit1 tx_empty
- bit2 rx_valid
- bit3 tx_overflow
- bit4 rx_overrun
- all other bits 0.
REQ-013 A write to STATUS, any data, SHALL clear tx_overflow and rx_overrun.
REQ-014 A read of IN_DATA SHALL return the RX holding register.
REQ-015 A write to IN_DATA, any data, SHALL acknowledge the RX word by clearing rx_valid.
REQ-016 The TX FIFO SHALL be a circular buffer with read/write pointers and a count of width log2(FifoDepth)+1; pointers SHALL wrap modulo FifoDepth.
REQ-017 The TX output SHALL behave as follows:
- tx_valid=1 iff count>0.
- tx_data SHALL present the head word whenever tx_valid=1.
- A pop SHALL occur on an edge where tx_valid and tx_ready are both 1.
REQ-018 Push-latency: a word pushed at edge N SHALL be visible on tx_data/tx_valid after edge N when the FIFO was empty.
REQ-019 On a push while full with no simultaneous pop, the word SHALL be dropped, tx_overflow SHALL be set, and FIFO state SHALL be unchanged.
REQ-020 On a simultaneous push and pop, both SHALL occur and count SHALL be unchanged, including when full.
REQ-021 When rx_strobe=1 and rx_valid=0, rx_data SHALL be latched and rx_valid set.
REQ-022 When rx_strobe=1 and rx_valid=1 with no simultaneous IN_DATA write, the new word SHALL be dropped and rx_overrun set.
REQ-023 When rx_strobe coincides with an IN_DATA acknowledge, the new word SHALL be latched, rx_valid SHALL remain 1, and no overrun SHALL occur.
REQ-024 When a STATUS clear coincides with a new overflow or overrun event, the event SHALL win and the flag SHALL be set.

Reset
REQ-025 Reset assertion SHALL immediately force:
- count=0, pointers=0, tx_valid=0, tx_data=0.
- rx_valid=0, RX holding register=0.
- tx_overflow=0, rx_overrun=0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 A write or strobe on the same edge as reset SHALL be ignored.
REQ-028 Reset mid-transfer SHALL discard all FIFO contents.

Verification
REQ-029 Write 0x1234 to 0x0005, then set addressM=0x0105 -> inM=0x1234 (alias); addressM=0x0006 -> the previously stored value.
REQ-030 With tx_ready=0, push 5 words 1..5 -> STATUS=0x0009, OUT_DATA read=4; then tx_ready=1 -> tx_data 1,2,3,4 on successive cycles, then tx_valid=0.
REQ-031 FIFO full, tx_ready=1, push 0xAAAA -> count stays 4, no overflow, 0xAAAA emerges fourth.
REQ-032 rx_strobe with 0x0041, then rx_strobe with 0x0042 -> IN_DATA=0x0041, STATUS bit4=1; write IN_DATA plus rx_strobe 0x0043 on the same edge -> IN_DATA=0x0043, rx_valid=1.
REQ-033 Assert reset asynchronously mid-cycle with count=3 -> tx_valid=0 and STATUS=0x0002 before the next edge.
REQ-034 Write STATUS with tx_overflow set -> STATUS bit3 reads 0 after the edge.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// Memory-mapped I/O controller: aliased data RAM, a TX FIFO behind OUT_DATA,
// an RX holding register behind IN_DATA, and sticky error flags in STATUS.
module mem_io_ctrl #(
    parameter int unsigned WordSize    = 16,
    parameter int unsigned MemAddrSize = 15,
    parameter int unsigned RamAddrSize = 8,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MemAddrSize-1:0] addressM,
    input  logic [WordSize-1:0]    outM,
    input  logic                   writeM,
    output logic [WordSize-1:0]    inM,
    output logic [WordSize-1:0]    tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [WordSize-1:0]    rx_data,
    input  logic                   rx_strobe
);

    localparam int unsigned PW = $clog2(FifoDepth);
    localparam int unsigned CW = PW + 1;

    localparam logic [MemAddrSize-1:0] ADDR_OUT    = MemAddrSize'(16'h6000);
    localparam logic [MemAddrSize-1:0] ADDR_STATUS = MemAddrSize'(16'h6001);
    localparam logic [MemAddrSize-1:0] ADDR_IN     = MemAddrSize'(16'h6002);

    logic [WordSize-1:0] ram      [2**RamAddrSize];
    logic [WordSize-1:0] fifo_mem [FifoDepth];

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d;
    logic                ovr_q, ovr_d;
    logic                rx_valid_q, rx_valid_d;
    logic [WordSize-1:0] rx_hold_q, rx_hold_d;

    logic mmio, sel_out, sel_status, sel_in;
    logic ram_we, push_req, push_ok, pop, full, empty;
    logic ovf_evt, ovr_evt, status_clr, rx_ack;

    assign mmio       = addressM[MemAddrSize-1];
    assign sel_out    = (addressM == ADDR_OUT);
    assign sel_status = (addressM == ADDR_STATUS);
    assign sel_in     = (addressM == ADDR_IN);

    assign ram_we     = writeM && !mmio && !reset;
    assign push_req   = writeM && sel_out;
    assign status_clr = writeM && sel_status;
    assign rx_ack     = writeM && sel_in;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(FifoDepth));
    assign tx_valid = !empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr_q] : '0;
    assign pop      = tx_valid && tx_ready;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;
    assign ovr_evt  = rx_strobe && rx_valid_q && !rx_ack;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        ovf_d      = (status_clr ? 1'b0 : ovf_q) | ovf_evt;
        ovr_d      = (status_clr ? 1'b0 : ovr_q) | ovr_evt;
        rx_valid_d = rx_valid_q;
        rx_hold_d  = rx_hold_q;
        if (rx_strobe && (!rx_valid_q || rx_ack)) begin
            rx_valid_d = 1'b1;
            rx_hold_d  = rx_data;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_hold_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            ovr_q      <= ovr_d;
            rx_valid_q <= rx_valid_d;
            rx_hold_q  <= rx_hold_d;
        end
    end

    // Storage arrays are not reset; writes are gated off while reset is high.
    always_ff @(posedge clk) begin
        if (ram_we) ram[addressM[RamAddrSize-1:0]] <= outM;
        if (push_ok && !reset) fifo_mem[wr_ptr_q] <= outM;
    end

    always_comb begin
        inM = '0;
        if (!mmio) begin
            inM = ram[addressM[RamAddrSize-1:0]];
        end else if (sel_out) begin
            inM = WordSize'(cnt_q);
        end else if (sel_status) begin
            inM[4:0] = {ovr_q, ovf_q, rx_valid_q, empty, full};
        end else if (sel_in) begin
            inM = rx_hold_q;
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl with default parameters.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] addressM = '0;
    logic [15:0] outM = '0;
    logic        writeM = 1'b0;
    logic [15:0] inM;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_strobe = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_io_ctrl #(.WordSize(16), .MemAddrSize(15), .RamAddrSize(8), .FifoDepth(4)) dut (
        .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
        .inM(inM), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_strobe(rx_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
        addressM = a;
        writeM   = 1'b0;
        #1;
        chk(tag, inM, exp);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        tick();
        writeM   = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0001 & 16'h0000);
        chk("rst_tx_data", tx_data, 16'h0000);
        rd("rst_status", 15'h6001, 16'h0002);
        rd("rst_in_data", 15'h6002, 16'h0000);
        tick();
        reset = 1'b0;
        tick();

        // RAM and aliasing
        wr(15'h0006, 16'h5678);
        wr(15'h0005, 16'h1234);
        rd("ram_alias", 15'h0105, 16'h1234);
        rd("ram_neighbour", 15'h0006, 16'h5678);
        tick();
        wr(15'h00FF, 16'h1111);
        wr(15'h7FFF, 16'h2222);
        rd("unmapped_read", 15'h7FFF, 16'h0000);
        rd("unmapped_no_write", 15'h00FF, 16'h1111);
        tick();

        // FIFO fill with overflow, then drain
        tx_ready = 1'b0;
        wr(15'h6000, 16'h0001);
        chk("push_latency_valid", {15'b0, tx_valid}, 16'h0001);
        chk("push_latency_data", tx_data, 16'h0001);
        wr(15'h6000, 16'h0002);
        wr(15'h6000, 16'h0003);
        wr(15'h6000, 16'h0004);
        wr(15'h6000, 16'h0005);
        rd("full_status", 15'h6001, 16'h0009);
        rd("full_count", 15'h6000, 16'h0004);
        tx_ready = 1'b1;
        chk("drain0", tx_data, 16'h0001);
        tick();
        chk("drain1", tx_data, 16'h0002);
        tick();
        chk("drain2", tx_data, 16'h0003);
        tick();
        chk("drain3", tx_data, 16'h0004);
        tick();
        chk("drained_valid", {15'b0, tx_valid}, 16'h0000);
        chk("drained_data", tx_data, 16'h0000);
        tx_ready = 1'b0;
        rd("drained_status", 15'h6001, 16'h000A);
        tick();

        // STATUS write clears overflow
        wr(15'h6001, 16'h0000);
        rd("ovf_cleared", 15'h6001, 16'h0002);
        tick();

        // Simultaneous push and pop while full
        wr(15'h6000, 16'h000A);
        wr(15'h6000, 16'h000B);
        wr(15'h6000, 16'h000C);
        wr(15'h6000, 16'h000D);
        tx_ready = 1'b1;
        wr(15'h6000, 16'hAAAA);
        tx_ready = 1'b0;
        rd("pushpop_count", 15'h6000, 16'h0004);
        rd("pushpop_status", 15'h6001, 16'h0001);
        chk("pushpop_head", tx_data, 16'h000B);
        tx_ready = 1'b1;
        tick();
        chk("pushpop_d1", tx_data, 16'h000C);
        tick();
        chk("pushpop_d2", tx_data, 16'h000D);
        tick();
        chk("pushpop_d3", tx_data, 16'hAAAA);
        tick();
        chk("pushpop_empty", {15'b0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // RX latch, overrun, ack+strobe
        rx_data = 16'h0041; rx_strobe = 1'b1;
        tick();
        rx_data = 16'h0042;
        tick();
        rx_strobe = 1'b0;
        rd("rx_first_kept", 15'h6002, 16'h0041);
        rd("rx_overrun", 15'h6001, 16'h0016);
        rx_data = 16'h0043; rx_strobe = 1'b1;
        wr(15'h6002, 16'hFFFF);
        rx_strobe = 1'b0;
        rd("rx_ack_strobe", 15'h6002, 16'h0043);
        rd("rx_ack_status", 15'h6001, 16'h0016);
        tick();
        wr(15'h6001, 16'h1234);
        rd("ovr_cleared", 15'h6001, 16'h0006);
        tick();
        // Overrun event coinciding with STATUS clear: event wins
        rx_data = 16'h0051; rx_strobe = 1'b1;
        wr(15'h6001, 16'h0000);
        rx_strobe = 1'b0;
        rd("clr_vs_ovr", 15'h6001, 16'h0016);
        wr(15'h6002, 16'h0000);
        wr(15'h6001, 16'h0000);
        rd("rx_acked", 15'h6001, 16'h0002);
        tick();

        // Async reset mid-cycle with three words queued
        wr(15'h0010, 16'h0BAD);
        wr(15'h6000, 16'h0101);
        wr(15'h6000, 16'h0202);
        wr(15'h6000, 16'h0303);
        rd("pre_reset_count", 15'h6000, 16'h0003);
        addressM = 15'h6001;
        #2 reset = 1'b1;
        #1;
        chk("async_tx_valid", {15'b0, tx_valid}, 16'h0000);
        chk("async_tx_data", tx_data, 16'h0000);
        chk("async_status", inM, 16'h0002);
        // Write and strobe during reset are ignored
        rx_data = 16'h0077; rx_strobe = 1'b1;
        wr(15'h0010, 16'hBEEF);
        rx_strobe = 1'b0;
        reset = 1'b0;
        rd("ram_write_in_reset", 15'h0010, 16'h0BAD);
        rd("ram_not_reset", 15'h0005, 16'h1234);
        rd("in_data_after_reset", 15'h6002, 16'h0000);
        tick();
        rd("count_after_reset", 15'h6000, 16'h0000);
        rd("status_after_reset", 15'h6001, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
